player_ctrl: RTL and testbench

PLAYER_CTRL -- requirements
Module: player_ctrl

---
 rtl/player_ctrl_pkg.sv | 16 +
 rtl/btn_sync.sv | 30 +++
 rtl/player_ctrl.sv | 124 ++++++++++++
 tb/tb_player_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_ctrl_pkg.sv
// Shared playfield and sprite constants for the player controller.
// Sprite geometry here must match the draw_sprite instance fed by player_ctrl.
package player_ctrl_pkg;

  localparam int RES_H            = 640;
  localparam int SPRITE_WIDTH     = 16;
  localparam int SPRITE_SCALE     = 2;
  localparam int PLAYER_Y_DEFAULT = 440;
  localparam int SPRITE_PIX_W     = SPRITE_WIDTH * SPRITE_SCALE;

  // Launch column is the horizontal centre of the drawn sprite.
  function automatic logic [9:0] shotColumn(input logic [9:0] x);
    return x + 10'(SPRITE_PIX_W / 2);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for a raw asynchronous button, plus a one-cycle
// rising-edge strobe taken from the synchronized level.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/player_ctrl.sv
// Player ship controller: per-frame horizontal movement, sprite start pulse and
// a READY/REQ/COOL fire handshake. Define PLAYER_AUTOFIRE_EN for hold-to-autofire.
module player_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int PLAYER_Y = PLAYER_Y_DEFAULT,
  parameter int STEP     = 2,
  parameter int X_MIN    = 8,
  parameter int X_MAX    = RES_H - SPRITE_PIX_W,
  parameter int COOLDOWN = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       frame_tick,
  input  logic       game_en,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  output logic       spr_start,
  output logic [9:0] spr_x,
  output logic       shot_valid,
  input  logic       shot_ready,
  output logic [9:0] shot_x
);

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_COOL  = 2'd2;

  localparam int         CNT_W   = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [9:0] X_RESET = 10'((X_MIN + X_MAX) / 2);

  logic left_lvl, left_rise;
  logic right_lvl, right_rise;
  logic fire_lvl, fire_rise;
  logic fire_trig;
  logic unused_sync;

  btn_sync u_sync_left  (.clk(clk), .rst_n(rst_n), .btn_i(btn_left),  .level_o(left_lvl),  .rise_o(left_rise));
  btn_sync u_sync_right (.clk(clk), .rst_n(rst_n), .btn_i(btn_right), .level_o(right_lvl), .rise_o(right_rise));
  btn_sync u_sync_fire  (.clk(clk), .rst_n(rst_n), .btn_i(btn_fire),  .level_o(fire_lvl),  .rise_o(fire_rise));

`ifdef PLAYER_AUTOFIRE_EN
  assign fire_trig   = fire_lvl;
  assign unused_sync = left_rise & right_rise & fire_rise;
`else
  assign fire_trig   = fire_rise;
  assign unused_sync = left_rise & right_rise & fire_lvl;
`endif

  assign spr_start = rst_n & game_en & (pixel_x == 10'd0) & (pixel_y == 10'(PLAYER_Y));

  logic [9:0]  spr_x_q, spr_x_d;
  logic [10:0] x_dec, x_inc;

  // One extra bit keeps the step arithmetic free of wrap-around at both edges.
  assign x_dec = {1'b0, spr_x_q} - 11'(STEP);
  assign x_inc = {1'b0, spr_x_q} + 11'(STEP);

  always_comb begin
    spr_x_d = spr_x_q;
    if (frame_tick && game_en) begin
      if (left_lvl && !right_lvl) begin
        spr_x_d = (x_dec[10] || (x_dec < 11'(X_MIN))) ? 10'(X_MIN) : x_dec[9:0];
      end else if (right_lvl && !left_lvl) begin
        spr_x_d = (x_inc > 11'(X_MAX)) ? 10'(X_MAX) : x_inc[9:0];
      end
    end
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       shot_x_q, shot_x_d;

  // A pending request ignores game_en, and ticks are only counted once in COOL.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shot_x_d = shot_x_q;
    case (state_q)
      ST_READY: begin
        if (fire_trig && game_en) begin
          state_d  = ST_REQ;
          shot_x_d = shotColumn(spr_x_q);
        end
      end
      ST_REQ: begin
        if (shot_ready) begin
          state_d = ST_COOL;
          cnt_d   = CNT_W'(COOLDOWN);
        end
      end
      ST_COOL: begin
        if (cnt_q == '0) begin
          state_d = ST_READY;
        end else if (frame_tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spr_x_q  <= X_RESET;
      state_q  <= ST_READY;
      cnt_q    <= '0;
      shot_x_q <= '0;
    end else begin
      spr_x_q  <= spr_x_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shot_x_q <= shot_x_d;
    end
  end

  assign spr_x      = spr_x_q;
  assign shot_valid = (state_q == ST_REQ);
  assign shot_x     = shot_x_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: the driver pushes expected sprite starts,
// frame positions and shot columns; a negedge monitor pops and compares them.
module tb_player_ctrl;

  localparam int PLAYER_Y = 440;
  localparam int STEP     = 2;
  localparam int X_MIN    = 8;
  localparam int X_MAX    = 608;
  localparam int COOLDOWN = 30;
  localparam int HALF_W   = 16;
  localparam int X_RESET  = 308;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pixelX = '0;
  logic [9:0] pixelY = '0;
  logic       frameTick = 1'b0;
  logic       gameEn = 1'b0;
  logic       btnLeft = 1'b0;
  logic       btnRight = 1'b0;
  logic       btnFire = 1'b0;
  logic       shotReady = 1'b0;
  logic       sprStart;
  logic [9:0] sprX;
  logic       shotValid;
  logic [9:0] shotX;

  int checks = 0;
  int errors = 0;
  int modelX = X_RESET;
  int lastX  = X_RESET;
  bit tickPending = 1'b0;
  int expSprX[$];
  int expShot[$];
  int expStart[$];

  player_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixelX), .pixel_y(pixelY),
    .frame_tick(frameTick), .game_en(gameEn), .btn_left(btnLeft),
    .btn_right(btnRight), .btn_fire(btnFire), .spr_start(sprStart),
    .spr_x(sprX), .shot_valid(shotValid), .shot_ready(shotReady), .shot_x(shotX)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One frame: hold buttons long enough to pass the synchronizer, then tick.
  task automatic applyStimulus(input bit l, input bit r, input bit f, input bit ge);
    btnLeft  = l;
    btnRight = r;
    btnFire  = f;
    gameEn   = ge;
    waitCycles(3);
    if (ge && l && !r) modelX = (modelX - STEP < X_MIN) ? X_MIN : modelX - STEP;
    else if (ge && r && !l) modelX = (modelX + STEP > X_MAX) ? X_MAX : modelX + STEP;
    expSprX.push_back(modelX);
    frameTick = 1'b1;
    waitCycles(1);
    frameTick = 1'b0;
  endtask

  task automatic coolFrames(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, $urandom_range(0, 3) != 0);
    end
  endtask

  task automatic fireShot(input int holdCycles, input bit tickOnHs);
    int exp;
    btnLeft  = 1'b0;
    btnRight = 1'b0;
    gameEn   = 1'b1;
    exp = modelX + HALF_W;
    expShot.push_back(exp);
    btnFire = 1'b1;
    waitCycles(3);
    btnFire = 1'b0;
    checkOutput("fire_valid", shotValid, 1);
    for (int i = 0; i < holdCycles; i++) begin
      checkOutput("shot_valid_hold", shotValid, 1);
      checkOutput("shot_x_hold", shotX, exp);
      waitCycles(1);
    end
    shotReady = 1'b1;
    if (tickOnHs) begin
      expSprX.push_back(modelX);
      frameTick = 1'b1;
    end
    waitCycles(1);
    shotReady = 1'b0;
    frameTick = 1'b0;
    checkOutput("shot_valid_drop", shotValid, 0);
  endtask

  task automatic discardPress();
    btnFire = 1'b1;
    waitCycles(4);
    btnFire = 1'b0;
    waitCycles(2);
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst_n) begin
      tickPending = 1'b0;
      lastX = X_RESET;
    end else begin
      if (sprStart) begin
        if (expStart.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spr_start_unexpected actual=(%0d,%0d) expected=none", pixelX, pixelY);
        end else begin
          checkOutput("spr_start_pos", {12'd0, pixelY, pixelX}, expStart.pop_front());
        end
      end
      if (tickPending) begin
        if (expSprX.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spr_x_frame actual=%0d expected=none", sprX);
        end else begin
          lastX = expSprX.pop_front();
          checkOutput("spr_x_frame", sprX, lastX);
        end
      end else if (sprX != 10'(lastX)) begin
        checks++;
        errors++;
        $display("[TB] FAIL spr_x_stray actual=%0d expected=%0d", sprX, lastX);
      end
      tickPending = frameTick;
      if (shotValid && shotReady) begin
        if (expShot.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL shot_unexpected actual=%0d expected=none", shotX);
        end else begin
          checkOutput("shot_x_handshake", shotX, expShot.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] player_ctrl scoreboard bench");
    pixelX = 10'd0;
    pixelY = 10'(PLAYER_Y);
    gameEn = 1'b1;
    waitCycles(3);
    checkOutput("reset_spr_x", sprX, X_RESET);
    checkOutput("reset_spr_start", sprStart, 0);
    checkOutput("reset_shot_valid", shotValid, 0);
    checkOutput("reset_shot_x", shotX, 0);
    pixelX = 10'd5;
    pixelY = 10'd0;
    waitCycles(1);
    rst_n = 1'b1;
    waitCycles(2);

    for (int y = PLAYER_Y - 4; y <= PLAYER_Y + 4; y++) begin
      for (int x = 0; x < 800; x++) begin
        pixelX = 10'(x);
        pixelY = 10'(y);
        if (x == 0 && y == PLAYER_Y) expStart.push_back((y << 10) | x);
        waitCycles(1);
      end
    end
    gameEn = 1'b0;
    for (int y = PLAYER_Y - 1; y <= PLAYER_Y + 1; y++) begin
      for (int x = 0; x < 8; x++) begin
        pixelX = 10'(x);
        pixelY = 10'(y);
        waitCycles(1);
      end
    end
    pixelX = 10'd5;
    pixelY = 10'd0;
    gameEn = 1'b1;

    for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("right_saturate", sprX, X_MAX);
    while (modelX > X_MIN) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("left_clamp", sprX, X_MIN);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("both_held", sprX, X_MIN + STEP);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("game_disabled", sprX, X_MIN + STEP);

    coolFrames(40);
    while (modelX < 100) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    while (modelX > 100) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    fireShot(5, 1'b0);
    coolFrames(29);
    discardPress();
    coolFrames(1);
    waitCycles(4);
    checkOutput("discard_not_queued", shotValid, 0);
    fireShot(3, 1'b1);
    coolFrames(29);
    discardPress();
    coolFrames(1);
    waitCycles(4);
    checkOutput("tick_on_handshake_ignored", shotValid, 0);
    fireShot($urandom_range(0, 6), 1'b0);
    coolFrames(31);

    for (int k = 0; k < 3; k++) begin
      coolFrames($urandom_range(5, 15));
      fireShot($urandom_range(0, 6), $urandom_range(0, 1));
      coolFrames(31);
    end

    shotReady = 1'b1;
`ifdef PLAYER_AUTOFIRE_EN
    for (int i = 0; i < (100 / (COOLDOWN + 1)) + 1; i++) expShot.push_back(modelX + HALF_W);
`else
    expShot.push_back(modelX + HALF_W);
`endif
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(5);
    btnFire = 1'b0;
    shotReady = 1'b0;
    checkOutput("hold_fire_shots", expShot.size(), 0);
    coolFrames(35);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    gameEn = 1'b1;
    btnFire = 1'b1;
    waitCycles(3);
    btnFire = 1'b0;
    checkOutput("pre_reset_valid", shotValid, 1);
    waitCycles(2);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_drops_valid", shotValid, 0);
    checkOutput("reset_mid_spr_x", sprX, X_RESET);
    checkOutput("reset_mid_shot_x", shotX, 0);
    modelX = X_RESET;
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2);
    fireShot(2, 1'b0);
    waitCycles(5);

    checkOutput("shot_queue_empty", expShot.size(), 0);
    checkOutput("frame_queue_empty", expSprX.size(), 0);
    checkOutput("start_queue_empty", expStart.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
